// File: rtl/instr_capture_fifo.sv
// instr_capture_fifo: captures {data_b, data_a} on each rising edge of the PIO write strobe
// into a show-ahead FIFO and presents entries to the GPU core over valid/ready.
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   data_a, data_b          PIO data words (low / high half of an instruction)
//   wrreg                   write-strobe PIO level; each 0->1 transition pushes one entry
//   instr_data/valid/ready  head entry and handshake towards the GPU core
//   wrfull, level           FIFO full flag and entry count (0..DEPTH)
//   overflow, overflow_clr  sticky dropped-push flag and its synchronous clear
module instr_capture_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   data_a,
    input  logic [DATA_W-1:0]   data_b,
    input  logic                wrreg,
    output logic [2*DATA_W-1:0] instr_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic                wrfull,
    output logic [AW:0]         level,
    output logic                overflow,
    input  logic                overflow_clr
);
    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         count;
    logic                wrreg_q, push, pop, accept;
    assign push        = wrreg & ~wrreg_q;
    assign pop         = instr_valid & instr_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept      = push & (~wrfull | pop);
    assign instr_valid = count != '0;
    assign wrfull      = count == (AW+1)'(DEPTH);
    assign level       = count;
    assign instr_data  = mem[rd_ptr];
    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {data_b, data_a};
    // wrreg_q resets high so a strobe held high through reset release does not push.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wrreg_q  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wrreg_q  <= wrreg;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + (AW+1)'(accept) - (AW+1)'(pop);
            overflow <= (push & ~accept) | (overflow & ~overflow_clr);
        end
endmodule

// File: tb/tb_instr_capture_fifo.sv
// tb_instr_capture_fifo: directed tests for instr_capture_fifo.
module tb_instr_capture_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_a = '0, data_b = '0;
    logic        wrreg = 1'b0, instr_ready = 1'b0, overflow_clr = 1'b0;
    logic [63:0] instr_data;
    logic        instr_valid, wrfull, overflow;
    logic [4:0]  level;
    int          n_checks = 0, n_fail = 0;

    instr_capture_fifo #(.DATA_W(32), .DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset_n(reset_n), .data_a(data_a), .data_b(data_b), .wrreg(wrreg),
        .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .wrfull(wrfull), .level(level), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        data_a = a;
        data_b = b;
        wrreg = 1'b1;
        tick();
        wrreg = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wrreg = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_checks++;
        if (wrfull !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got full=%b ovf=%b exp=0 0", wrfull, overflow); end
        wrreg = 1'b0;
        tick();
        data_a = 32'h0000_0011;
        data_b = 32'h8000_0022;
        wrreg = 1'b1;
        tick();
        n_checks++;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", instr_valid); end
        n_checks++;
        if (instr_data !== 64'h8000_0022_0000_0011) begin n_fail++; $display("FAIL first_data got=%h exp=8000002200000011", instr_data); end
        n_checks++;
        if (level !== 5'd1) begin n_fail++; $display("FAIL first_level got=%0d exp=1", level); end
        wrreg = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL first_pop_level got=%0d exp=0", level); end
    endtask

    task automatic test_hold();
        data_a = 32'h5;
        data_b = 32'h6;
        wrreg = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (level !== 5'd1) begin n_fail++; $display("FAIL hold_level got=%0d exp=1", level); end
        n_checks++;
        if (instr_data !== 64'h0000_0006_0000_0005) begin n_fail++; $display("FAIL hold_data got=%h exp=0000000600000005", instr_data); end
        wrreg = 1'b0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL hold_pop_level got=%0d exp=0", level); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) push(32'(i), ~32'(i));
        n_checks++;
        if (wrfull !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL fill got full=%b level=%0d exp=1 16", wrfull, level); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf got=%b exp=0", overflow); end
        data_a = 32'hDEAD;
        data_b = 32'hBEEF;
        wrreg = 1'b1;
        overflow_clr = 1'b1;
        tick();
        n_checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin n_fail++; $display("FAIL ovf_set got ovf=%b level=%0d exp=1 16", overflow, level); end
        wrreg = 1'b0;
        overflow_clr = 1'b0;
        tick();
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
        instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr_data !== {~32'(i), 32'(i)})
                begin n_fail++; $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, instr_valid, instr_data, {~32'(i), 32'(i)}); end
            tick();
        end
        instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL drain_end got v=%b level=%0d exp=0 0", instr_valid, level); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), 32'h200 + 32'(i));
        data_a = 32'hABC;
        data_b = 32'hDEF;
        wrreg = 1'b1;
        instr_ready = 1'b1;
        tick();
        wrreg = 1'b0;
        n_checks++;
        if (level !== 5'd16 || wrfull !== 1'b1) begin n_fail++; $display("FAIL full_pp got level=%0d full=%b exp=16 1", level, wrfull); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_ovf got=%b exp=0", overflow); end
        for (int i = 1; i < 17; i++) begin
            logic [63:0] exp;
            exp = (i == 16) ? 64'h0000_0DEF_0000_0ABC : {32'h200 + 32'(i), 32'h100 + 32'(i)};
            n_checks++;
            if (instr_valid !== 1'b1 || instr_data !== exp)
                begin n_fail++; $display("FAIL full_pp_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, instr_valid, instr_data, exp); end
            tick();
        end
        instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_end got v=%b exp=0", instr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q[$];
        logic        prev, p, po;
        int          pushes = 0, guard = 0;
        prev = wrreg;
        while (pushes < 40 && guard < 1000) begin
            guard++;
            wrreg = ~wrreg;
            data_a = 32'h1000 + 32'(pushes);
            data_b = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            p = wrreg & ~prev;
            po = instr_ready && q.size() > 0;
            if (po) begin
                n_checks++;
                if (instr_data !== q[0]) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", instr_data, q[0]); end
                void'(q.pop_front());
            end
            if (p && (q.size() < 16 || po)) q.push_back({data_b, data_a});
            if (p) pushes++;
            prev = wrreg;
            tick();
            n_checks++;
            if (level !== 5'(q.size()) || level > 5'd16) begin n_fail++; $display("FAIL b2b_level got=%0d exp=%0d", level, q.size()); end
        end
        wrreg = 1'b0;
        instr_ready = 1'b1;
        guard = 0;
        while (q.size() > 0 && guard < 40) begin
            guard++;
            n_checks++;
            if (instr_valid !== 1'b1 || instr_data !== q[0]) begin n_fail++; $display("FAIL b2b_drain got v=%b d=%h exp v=1 d=%h", instr_valid, instr_data, q[0]); end
            void'(q.pop_front());
            tick();
        end
        instr_ready = 1'b0;
        n_checks++;
        if (q.size() != 0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got v=%b left=%0d exp=0 0", instr_valid, q.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) push(32'h700 + 32'(i), 32'h7);
        n_checks++;
        if (level !== 5'd7) begin n_fail++; $display("FAIL mid_level got=%0d exp=7", level); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (level !== 5'd0 || instr_valid !== 1'b0 || wrfull !== 1'b0 || overflow !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset got level=%0d v=%b full=%b ovf=%b exp=0 0 0 0", level, instr_valid, wrfull, overflow); end
        tick();
        reset_n = 1'b1;
        tick();
        push(32'hCAFE, 32'hBEEF);
        n_checks++;
        if (instr_valid !== 1'b1 || level !== 5'd1 || instr_data !== 64'h0000_BEEF_0000_CAFE)
            begin n_fail++; $display("FAIL mid_head got v=%b level=%0d d=%h exp 1 1 0000beef0000cafe", instr_valid, level, instr_data); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_capture_fifo.md
Name: instr_capture_fifo

Overview:
- Sits directly downstream of the two 32-bit Avalon PIO output registers (data A, data B) and the write-strobe PIO in the HPS-to-GPU path.
- On each rising edge of the strobe, captures {data_b, data_a} as one 64-bit instruction into a show-ahead FIFO.
- Presents buffered instructions to the GPU core over a valid/ready handshake.
- Returns full and overflow status for an Avalon PIO input port.

Parameters:
- DATA_W, 32: width of each PIO data word; FIFO entry width is 2*DATA_W.
- DEPTH, 16: FIFO entries; must be a power of 2 and at least 2.
- AW, 4: log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock, same domain as the PIOs.
- reset_n  in  1  asynchronous, active-low reset.
- data_a  in  DATA_W  data A PIO out_port (low half of the instruction).
- data_b  in  DATA_W  data B PIO out_port (high half of the instruction).
- wrreg  in  1  write-strobe PIO level; each 0->1 transition pushes one entry.
- instr_data  out  2*DATA_W  head entry, {data_b, data_a}.
- instr_valid  out  1  FIFO not empty.
- instr_ready  in  1  GPU consumes the head entry when instr_valid & instr_ready.
- wrfull  out  1  FIFO holds DEPTH entries.
- level  out  AW+1  current entry count, 0..DEPTH.
- overflow  out  1  sticky flag: a push was dropped.
- overflow_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Pointers and count go to 0; instr_valid=0, wrfull=0, level=0, overflow=0.
  - instr_data reads memory at pointer 0; its value is don't-care while instr_valid=0.
  - wrreg_q (the edge-detect register) resets to 1. A wrreg held high through reset release does not push; wrreg must return to 0 first.
  - Reset mid-operation discards all entries. No partial state survives.
- Edge detect:
  - push = wrreg & ~wrreg_q; wrreg_q <= wrreg every cycle.
  - A level held high for N cycles produces exactly one push.
  - Pulses of 1 cycle are legal; back-to-back pulses 0,1,0,1 push every other cycle.
- Push:
  - data_a and data_b are sampled on the same clock edge where push=1.
  - The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - Latency: instr_valid rises the cycle after the push edge. There is no combinational bypass.
- Pop:
  - pop = instr_valid & instr_ready; rd_ptr increments modulo DEPTH.
  - instr_data is show-ahead: it reflects the new head the cycle after a pop.
  - instr_ready while empty is ignored.
- Count and flags:
  - level += push_accepted - pop.
  - wrfull = (level==DEPTH).
  - instr_valid = (level!=0).
  - All flags are registered or derived from registered count; none depends combinationally on inputs.
- Full boundary:
  - push while full and no pop: entry dropped, pointers unchanged, overflow <= 1.
  - push while full with pop in the same cycle: push accepted, level stays DEPTH, no overflow.
- Empty boundary: push and instr_ready in the same cycle while empty results in push only, level=1.
- Simultaneous push and pop when not full: both occur, level unchanged.
- Overflow:
  - Set has priority over overflow_clr in the same cycle.
  - Otherwise overflow_clr=1 clears it the next edge.
- Wrap-around: pointers wrap silently. Full and empty are distinguished by count, not by pointer equality.

Test Plan:
- Reset release with wrreg=1, then hold 5 cycles: no push, level=0, instr_valid=0. Then drop wrreg to 0 and raise it with data_a=0x00000011, data_b=0x80000022: the next cycle shows instr_valid=1, instr_data=0x8000002200000011, level=1.
- Hold wrreg high for 10 cycles with instr_ready=0: exactly one entry, level=1.
- Push 16 distinct words (data_a=i, data_b=~i) with instr_ready=0: wrfull=1, level=16. A 17th push sets overflow=1, level stays 16. Then drain with instr_ready=1: values i=0..15 come out in order, one per cycle, and instr_valid drops after the 16th.
- FIFO full, push and pop in the same cycle: level stays 16, overflow stays 0, and the pushed entry emerges last.
- Run 40 push/pop pairs interleaved, with a random instr_ready duty of 50%, to exercise pointer wrap: output sequence equals input sequence and level never exceeds 16.
- Assert reset_n low mid-stream with level=7: all outputs are 0 immediately. After release, the first new push appears as the head, with no stale data.
